// File: rtl/platform_scroller.sv
// Doodle Jump platform position table: initialises slots at a fixed pitch,
// scrolls them down once per frame and recycles fallen platforms to the top.
module platform_scroller #(
   parameter int NUM_PLAT = 16,
   parameter int SCREEN_H = 480,
   parameter int SPACING  = 30,
   parameter int MIN_X    = 4
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   frame_clk,
   input  logic                   start,
   input  logic [4:0]             scroll_amt,
   input  logic [9:0]             rand_x,
   output logic [NUM_PLAT*10-1:0] plat_x,
   output logic [NUM_PLAT*10-1:0] plat_y,
   output logic                   busy,
   output logic                   update_done,
   output logic                   frame_overrun,
   output logic [15:0]            recycle_cnt
);

   localparam int IW = $clog2(NUM_PLAT);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PLAT - 1);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCROLL, ST_DONE} state_t;

   state_t        state_reg, state_next;
   logic [IW-1:0] idx_reg;
   logic [4:0]    lat_reg;
   logic [15:0]   cnt_reg;
   logic          meta_reg, sync_reg, sync_d_reg;
   logic          fe;
   logic          init_we, scroll_we;
   logic [9:0]    new_x, cur_y, wrap_y;
   logic [10:0]   ny;
   logic          wrap;
   logic          unused_bits;

   // Only 9 random bits are used so X stays within 4..515.
   assign unused_bits = rand_x[9];

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         meta_reg   <= 1'b0;
         sync_reg   <= 1'b0;
         sync_d_reg <= 1'b0;
      end else begin
         meta_reg   <= frame_clk;
         sync_reg   <= meta_reg;
         sync_d_reg <= sync_reg;
      end
   end

   assign fe = sync_reg & ~sync_d_reg;

   assign new_x  = {1'b0, rand_x[8:0]} + 10'(MIN_X);
   assign cur_y  = plat_y[idx_reg*10 +: 10];
   assign ny     = {1'b0, cur_y} + {6'b0, lat_reg};
   assign wrap   = (ny >= 11'(SCREEN_H));
   assign wrap_y = 10'(ny - 11'(SCREEN_H));

   always_ff @(posedge Clk) begin
      if (!Reset) state_reg <= ST_INIT;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_INIT:   if (idx_reg == LAST_IDX) state_next = ST_IDLE;
         ST_IDLE:   if (fe) state_next = (scroll_amt != 5'd0) ? ST_SCROLL : ST_DONE;
         ST_SCROLL: if (idx_reg == LAST_IDX) state_next = ST_DONE;
         default:   state_next = ST_IDLE;
      endcase
      if (start) state_next = ST_INIT;
   end

   always_comb begin
      busy          = (state_reg != ST_IDLE);
      update_done   = (state_reg == ST_DONE);
      frame_overrun = fe && (state_reg != ST_IDLE) && !start;
      init_we       = (state_reg == ST_INIT) && !start;
      scroll_we     = (state_reg == ST_SCROLL) && !start;
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         idx_reg <= '0;
         lat_reg <= 5'd0;
         cnt_reg <= 16'd0;
      end else if (start) begin
         idx_reg <= '0;
         cnt_reg <= 16'd0;
      end else begin
         case (state_reg)
            ST_INIT: begin
               idx_reg <= idx_reg + 1'b1;
               cnt_reg <= 16'd0;
            end
            ST_IDLE: begin
               if (fe) begin
                  idx_reg <= '0;
                  lat_reg <= scroll_amt;
               end
            end
            ST_SCROLL: begin
               idx_reg <= idx_reg + 1'b1;
               if (wrap && cnt_reg != 16'hFFFF) cnt_reg <= cnt_reg + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign recycle_cnt = cnt_reg;

   generate
      for (genvar gi = 0; gi < NUM_PLAT; gi++) begin : g_slot
         logic [9:0] x_reg, y_reg;
         logic       sel;

         assign sel = (idx_reg == IW'(gi));

         always_ff @(posedge Clk) begin
            if (!Reset) begin
               x_reg <= 10'd0;
               y_reg <= 10'd0;
            end else if (init_we && sel) begin
               x_reg <= new_x;
               y_reg <= 10'(gi * SPACING);
            end else if (scroll_we && sel) begin
               if (wrap) begin
                  x_reg <= new_x;
                  y_reg <= wrap_y;
               end else begin
                  y_reg <= ny[9:0];
               end
            end
         end

         assign plat_x[gi*10 +: 10] = x_reg;
         assign plat_y[gi*10 +: 10] = y_reg;
      end
   endgenerate

endmodule

// File: tb/tb_platform_scroller.sv
// Directed bench for platform_scroller: init layout, scroll passes, wrap,
// zero-scroll, overrun and mid-pass start/reset aborts.
module tb_platform_scroller;

   logic         Clk = 1'b0;
   logic         Reset = 1'b0;
   logic         frame_clk = 1'b0;
   logic         start = 1'b0;
   logic [4:0]   scroll_amt = 5'd0;
   logic [9:0]   rand_x = 10'd0;
   logic [159:0] plat_x, plat_y;
   logic         busy, update_done, frame_overrun;
   logic [15:0]  recycle_cnt;

   int vectors = 0;
   int miscompares = 0;
   int exp_x[16];
   int exp_y[16];
   int exp_cnt = 0;

   platform_scroller dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
      .scroll_amt(scroll_amt), .rand_x(rand_x), .plat_x(plat_x), .plat_y(plat_y),
      .busy(busy), .update_done(update_done), .frame_overrun(frame_overrun),
      .recycle_cnt(recycle_cnt)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int px(input int i);
      return int'(plat_x[i*10 +: 10]);
   endfunction

   function automatic int py(input int i);
      return int'(plat_y[i*10 +: 10]);
   endfunction

   task automatic check_table(input string tag);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("%s_x%0d", tag, i), px(i), exp_x[i]);
         chk($sformatf("%s_y%0d", tag, i), py(i), exp_y[i]);
      end
      chk({tag, "_cnt"}, recycle_cnt, exp_cnt);
   endtask

   task automatic set_init_model(input int rx);
      for (int i = 0; i < 16; i++) begin
         exp_x[i] = (rx & 511) + 4;
         exp_y[i] = 30 * i;
      end
      exp_cnt = 0;
   endtask

   // Raises frame_clk after a negedge; edge e is the e-th posedge after that.
   task automatic run_frame(input int amt, input int rx, input bit second);
      int done_n = 0, done_e = 0, ovr_n = 0, ovr_e = 0;
      @(negedge Clk);
      scroll_amt = 5'(amt);
      rand_x     = 10'(rx);
      frame_clk  = 1'b1;
      for (int e = 1; e <= 26; e++) begin
         @(negedge Clk);
         if (update_done) begin done_n++; done_e = e; end
         if (frame_overrun) begin ovr_n++; ovr_e = e; end
         if (e == 3) frame_clk = 1'b0;
         if (e == 5 && amt != 0) scroll_amt = 5'd31;
         if (second && e == 6) frame_clk = 1'b1;
         if (e == 20) frame_clk = 1'b0;
      end
      $display("frame amt=%0d rx=%0h second=%0d done_edge=%0d overrun_edge=%0d",
               amt, rx, second, done_e, ovr_e);
      chk("done_count", done_n, 1);
      chk("done_latency", done_e, (amt != 0) ? 19 : 3);
      chk("overrun_count", ovr_n, second ? 1 : 0);
      if (second) chk("overrun_edge", ovr_e, 8);
      chk("idle_busy", busy, 0);
      for (int i = 0; i < 16; i++) begin
         exp_y[i] = exp_y[i] + amt;
         if (exp_y[i] >= 480) begin
            exp_y[i] = exp_y[i] - 480;
            exp_x[i] = (rx & 511) + 4;
            exp_cnt++;
         end
      end
      check_table($sformatf("frame%0d", amt));
   endtask

   task automatic wait_init(output int n, output int done_n);
      n = 1;
      done_n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge Clk);
         if (update_done) done_n++;
         if (!busy) break;
         n++;
      end
   endtask

   task automatic run_abort(input bit use_reset, input int rx);
      int n, done_n;
      @(negedge Clk);
      scroll_amt = 5'd5;
      rand_x     = 10'(rx);
      frame_clk  = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         @(negedge Clk);
         if (e == 3) frame_clk = 1'b0;
      end
      if (use_reset) Reset = 1'b0;
      else           start = 1'b1;
      @(negedge Clk);
      Reset = 1'b1;
      start = 1'b0;
      chk("abort_busy", busy, 1);
      chk("abort_cnt", recycle_cnt, 0);
      chk("abort_done", update_done, 0);
      if (use_reset) chk("abort_rst_y15", py(15), 0);
      wait_init(n, done_n);
      $display("abort reset=%0d rx=%0h init_cycles=%0d", use_reset, rx, n);
      chk("abort_init_cycles", n, 16);
      chk("abort_no_done", done_n, 0);
      set_init_model(rx);
      check_table(use_reset ? "rst_init" : "start_init");
   endtask

   initial begin
      int n, done_n;
      rand_x = 10'h005;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rst_x0", px(0), 0);
      chk("rst_y15", py(15), 0);
      chk("rst_busy", busy, 1);
      chk("rst_done", update_done, 0);
      chk("rst_ovr", frame_overrun, 0);
      chk("rst_cnt", recycle_cnt, 0);
      Reset = 1'b1;
      wait_init(n, done_n);
      $display("init cycles=%0d", n);
      chk("init_cycles", n, 16);
      chk("init_no_done", done_n, 0);
      set_init_model(5);
      chk("init_y15", py(15), 450);
      chk("init_x3", px(3), 9);
      check_table("init");

      repeat (4) run_frame(5, 5, 1'b0);
      chk("pre_wrap_y15", py(15), 470);
      run_frame(20, 10'h3FF, 1'b0);
      chk("wrap_y15", py(15), 10);
      chk("wrap_x15", px(15), 515);
      chk("wrap_cnt", recycle_cnt, 1);
      run_frame(0, 10'h123, 1'b0);
      run_frame(5, 5, 1'b1);
      run_frame(5, 5, 1'b0);

      run_abort(1'b0, 10'h2A3);
      chk("start_x0", px(0), 167);
      run_frame(31, 10'h155, 1'b0);
      chk("wrap31_y15", py(15), 1);
      chk("wrap31_x15", px(15), 345);
      run_abort(1'b1, 10'h0F0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
